// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register: latches decode control and operands for EX.
// It detects load-use hazards (Stall_o) and squashes the slot on Flush_i.
// Ports: clk, reset (sync, active low), decode control/data/index inputs,
//   Flush_i, comb Stall_o, registered copies of every input, Valid_o.
// Option ID_EX_STALL_CNT_EN adds the Stall_Cnt_o and Flush_Cnt_o counters.
module id_ex_stage_register #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Branch_i,
  input  logic                  Mem_Read_i,
  input  logic                  Mem_to_Reg_i,
  input  logic                  Mem_Write_i,
  input  logic                  ALU_Src_i,
  input  logic                  Reg_Write_i,
  input  logic [2:0]            ALU_Op_i,
  input  logic [DATA_WIDTH-1:0] PC_i,
  input  logic [DATA_WIDTH-1:0] RS1_Data_i,
  input  logic [DATA_WIDTH-1:0] RS2_Data_i,
  input  logic [DATA_WIDTH-1:0] Imm_i,
  input  logic [4:0]            RS1_Addr_i,
  input  logic [4:0]            RS2_Addr_i,
  input  logic [4:0]            RD_Addr_i,
  input  logic [2:0]            Funct3_i,
  input  logic                  Funct7_b5_i,
  input  logic                  Flush_i,
  output logic                  Stall_o,
  output logic                  Branch_o,
  output logic                  Mem_Read_o,
  output logic                  Mem_to_Reg_o,
  output logic                  Mem_Write_o,
  output logic                  ALU_Src_o,
  output logic                  Reg_Write_o,
  output logic [2:0]            ALU_Op_o,
  output logic [DATA_WIDTH-1:0] PC_o,
  output logic [DATA_WIDTH-1:0] RS1_Data_o,
  output logic [DATA_WIDTH-1:0] RS2_Data_o,
  output logic [DATA_WIDTH-1:0] Imm_o,
  output logic [4:0]            RS1_Addr_o,
  output logic [4:0]            RS2_Addr_o,
  output logic [4:0]            RD_Addr_o,
  output logic [2:0]            Funct3_o,
  output logic                  Funct7_b5_o,
  output logic                  Valid_o
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [31:0]           Stall_Cnt_o,
  output logic [31:0]           Flush_Cnt_o
`endif
);

  localparam logic [2:0] OP_U = 3'b010;

  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [2:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic [DATA_WIDTH-1:0] imm;
    logic [4:0]            rs1_addr;
    logic [4:0]            rs2_addr;
    logic [4:0]            rd_addr;
    logic [2:0]            funct3;
    logic                  funct7_b5;
  } data_t;

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;
  data_t data_d;
  data_t data_q;
  logic  valid_q;

  logic use_rs1;
  logic use_rs2;
  logic rs1_hit;
  logic rs2_hit;
  logic hazard;
  logic bubble;

  always_comb begin
    ctrl_d.branch     = Branch_i;
    ctrl_d.mem_read   = Mem_Read_i;
    ctrl_d.mem_to_reg = Mem_to_Reg_i;
    ctrl_d.mem_write  = Mem_Write_i;
    ctrl_d.alu_src    = ALU_Src_i;
    ctrl_d.reg_write  = Reg_Write_i;
    ctrl_d.alu_op     = ALU_Op_i;
  end

  always_comb begin
    data_d.pc        = PC_i;
    data_d.rs1_data  = RS1_Data_i;
    data_d.rs2_data  = RS2_Data_i;
    data_d.imm       = Imm_i;
    data_d.rs1_addr  = RS1_Addr_i;
    data_d.rs2_addr  = RS2_Addr_i;
    data_d.rd_addr   = RD_Addr_i;
    data_d.funct3    = Funct3_i;
    data_d.funct7_b5 = Funct7_b5_i;
  end

  // U-type has no rs1; rs2 is read by register-register ops and stores
  // (a store's rs2 is the data, even though ALU_Src selects the imm).
  assign use_rs1 = (ALU_Op_i != OP_U);
  assign use_rs2 = ~ALU_Src_i | Mem_Write_i;

  assign rs1_hit = use_rs1 & (data_q.rd_addr == RS1_Addr_i);
  assign rs2_hit = use_rs2 & (data_q.rd_addr == RS2_Addr_i);

  // Loads into x0 never produce a value anyone waits for.
  assign hazard = ctrl_q.mem_read
                & valid_q
                & (data_q.rd_addr != 5'd0)
                & (rs1_hit | rs2_hit);

  // A flush kills the ID instruction upstream, so no stall is needed.
  assign Stall_o = hazard & ~Flush_i;
  assign bubble  = Flush_i | hazard;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (bubble) begin
      ctrl_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      valid_q <= 1'b1;
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Stall_o already excludes flush cycles, so the two never step together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (Flush_i) begin
      flush_cnt_q <= flush_cnt_q + 32'd1;
    end else if (Stall_o) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign Stall_Cnt_o = stall_cnt_q;
  assign Flush_Cnt_o = flush_cnt_q;
`endif

  assign Branch_o     = ctrl_q.branch;
  assign Mem_Read_o   = ctrl_q.mem_read;
  assign Mem_to_Reg_o = ctrl_q.mem_to_reg;
  assign Mem_Write_o  = ctrl_q.mem_write;
  assign ALU_Src_o    = ctrl_q.alu_src;
  assign Reg_Write_o  = ctrl_q.reg_write;
  assign ALU_Op_o     = ctrl_q.alu_op;

  assign PC_o         = data_q.pc;
  assign RS1_Data_o   = data_q.rs1_data;
  assign RS2_Data_o   = data_q.rs2_data;
  assign Imm_o        = data_q.imm;
  assign RS1_Addr_o   = data_q.rs1_addr;
  assign RS2_Addr_o   = data_q.rs2_addr;
  assign RD_Addr_o    = data_q.rd_addr;
  assign Funct3_o     = data_q.funct3;
  assign Funct7_b5_o  = data_q.funct7_b5;

  assign Valid_o      = valid_q;

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Bench for id_ex_stage_register: directed load-use/flush cases plus
// random traffic, checked through a scoreboard against a slot model.
module tb_id_ex_stage_register;

  typedef struct packed {
    logic        branch;
    logic        mem_read;
    logic        mem_to_reg;
    logic        mem_write;
    logic        alu_src;
    logic        reg_write;
    logic [2:0]  alu_op;
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        f7;
    logic        valid;
  } ins_t;

  typedef struct packed {
    ins_t        o;
    logic        stall;
    logic        chk_data;
    logic [31:0] scnt;
    logic [31:0] fcnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic br_i, mr_i, m2r_i, mw_i, as_i, rw_i, f7_i, fl_i;
  logic [2:0] op_i, f3_i;
  logic [31:0] pc_i, d1_i, d2_i, imm_i;
  logic [4:0] a1_i, a2_i, rd_i;
  logic stall, br_o, mr_o, m2r_o, mw_o, as_o, rw_o, f7_o, vld_o;
  logic [2:0] op_o, f3_o;
  logic [31:0] pc_o, d1_o, d2_o, imm_o;
  logic [4:0] a1_o, a2_o, rd_o;
`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] scnt_o, fcnt_o;
`endif

  always #5 clk = ~clk;

  id_ex_stage_register #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .Branch_i(br_i), .Mem_Read_i(mr_i), .Mem_to_Reg_i(m2r_i),
    .Mem_Write_i(mw_i), .ALU_Src_i(as_i), .Reg_Write_i(rw_i),
    .ALU_Op_i(op_i), .PC_i(pc_i), .RS1_Data_i(d1_i),
    .RS2_Data_i(d2_i), .Imm_i(imm_i), .RS1_Addr_i(a1_i),
    .RS2_Addr_i(a2_i), .RD_Addr_i(rd_i), .Funct3_i(f3_i),
    .Funct7_b5_i(f7_i), .Flush_i(fl_i), .Stall_o(stall),
    .Branch_o(br_o), .Mem_Read_o(mr_o), .Mem_to_Reg_o(m2r_o),
    .Mem_Write_o(mw_o), .ALU_Src_o(as_o), .Reg_Write_o(rw_o),
    .ALU_Op_o(op_o), .PC_o(pc_o), .RS1_Data_o(d1_o),
    .RS2_Data_o(d2_o), .Imm_o(imm_o), .RS1_Addr_o(a1_o),
    .RS2_Addr_o(a2_o), .RD_Addr_o(rd_o), .Funct3_o(f3_o),
    .Funct7_b5_o(f7_o), .Valid_o(vld_o)
`ifdef ID_EX_STALL_CNT_EN
    , .Stall_Cnt_o(scnt_o), .Flush_Cnt_o(fcnt_o)
`endif
  );

  exp_t q[$];
  int   n_vec = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  ins_t        slot;
  logic        zeroed;
  logic [31:0] m_scnt, m_fcnt;
  logic        last_stall;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      chk("stall", 32'(stall), 32'(e.stall));
      chk("valid", 32'(vld_o), 32'(e.o.valid));
      chk("branch", 32'(br_o), 32'(e.o.branch));
      chk("mem_read", 32'(mr_o), 32'(e.o.mem_read));
      chk("mem_to_reg", 32'(m2r_o), 32'(e.o.mem_to_reg));
      chk("mem_write", 32'(mw_o), 32'(e.o.mem_write));
      chk("alu_src", 32'(as_o), 32'(e.o.alu_src));
      chk("reg_write", 32'(rw_o), 32'(e.o.reg_write));
      chk("alu_op", 32'(op_o), 32'(e.o.alu_op));
      if (e.chk_data) begin
        chk("pc", pc_o, e.o.pc);
        chk("rs1_data", d1_o, e.o.rs1d);
        chk("rs2_data", d2_o, e.o.rs2d);
        chk("imm", imm_o, e.o.imm);
        chk("rs1_addr", 32'(a1_o), 32'(e.o.rs1a));
        chk("rs2_addr", 32'(a2_o), 32'(e.o.rs2a));
        chk("rd_addr", 32'(rd_o), 32'(e.o.rd));
        chk("funct3", 32'(f3_o), 32'(e.o.f3));
        chk("funct7b5", 32'(f7_o), 32'(e.o.f7));
      end
`ifdef ID_EX_STALL_CNT_EN
      chk("stall_cnt", scnt_o, e.scnt);
      chk("flush_cnt", fcnt_o, e.fcnt);
`endif
    end
  end

  function automatic ins_t rnd_ins();
    ins_t x;
    x.branch     = 1'($urandom);
    x.mem_read   = ($urandom_range(0, 9) < 3);
    x.mem_to_reg = 1'($urandom);
    x.mem_write  = 1'($urandom);
    x.alu_src    = 1'($urandom);
    x.reg_write  = 1'($urandom);
    x.alu_op     = 3'($urandom_range(0, 5));
    x.pc         = $urandom;
    x.rs1d       = $urandom;
    x.rs2d       = $urandom;
    x.imm        = $urandom;
    x.rs1a       = 5'($urandom_range(0, 7));
    x.rs2a       = 5'($urandom_range(0, 7));
    x.rd         = 5'($urandom_range(0, 7));
    x.f3         = 3'($urandom);
    x.f7         = 1'($urandom);
    x.valid      = 1'b0;
    return x;
  endfunction

  function automatic ins_t base(logic [4:0] rd, logic [4:0] r1,
                                logic [4:0] r2);
    ins_t x;
    x = rnd_ins();
    x.branch = 0; x.mem_read = 0; x.mem_to_reg = 0;
    x.mem_write = 0; x.alu_src = 0; x.reg_write = 0;
    x.rd = rd; x.rs1a = r1; x.rs2a = r2;
    return x;
  endfunction

  function automatic ins_t r_add(logic [4:0] rd, logic [4:0] r1,
                                 logic [4:0] r2);
    ins_t x;
    x = base(rd, r1, r2);
    x.alu_op = 3'b000; x.reg_write = 1;
    return x;
  endfunction

  function automatic ins_t ld(logic [4:0] rd, logic [4:0] r1);
    ins_t x;
    x = base(rd, r1, 5'd0);
    x.alu_op = 3'b101; x.mem_read = 1; x.mem_to_reg = 1;
    x.alu_src = 1; x.reg_write = 1;
    return x;
  endfunction

  function automatic ins_t lui(logic [4:0] rd, logic [4:0] junk);
    ins_t x;
    x = base(rd, junk, 5'd0);
    x.alu_op = 3'b010; x.alu_src = 1; x.reg_write = 1;
    return x;
  endfunction

  function automatic ins_t st(logic [4:0] r1, logic [4:0] r2);
    ins_t x;
    x = base(5'd0, r1, r2);
    x.alu_op = 3'b100; x.alu_src = 1; x.mem_write = 1;
    return x;
  endfunction

  // One cycle: drive ID, record what EX must show now, advance the slot.
  task automatic step(ins_t x, logic fl = 1'b0, logic rs = 1'b1);
    exp_t e;
    logic rd1, rd2, dep;
    br_i = x.branch; mr_i = x.mem_read; m2r_i = x.mem_to_reg;
    mw_i = x.mem_write; as_i = x.alu_src; rw_i = x.reg_write;
    op_i = x.alu_op; pc_i = x.pc; d1_i = x.rs1d; d2_i = x.rs2d;
    imm_i = x.imm; a1_i = x.rs1a; a2_i = x.rs2a; rd_i = x.rd;
    f3_i = x.f3; f7_i = x.f7; fl_i = fl; reset = rs;
    rd1 = (x.alu_op != 3'b010);
    rd2 = !x.alu_src || x.mem_write;
    dep = slot.valid && slot.mem_read && (slot.rd != 0) &&
          ((rd1 && x.rs1a == slot.rd) || (rd2 && x.rs2a == slot.rd));
    e.o = slot;
    e.stall = dep && !fl;
    e.chk_data = slot.valid || zeroed;
    e.scnt = m_scnt;
    e.fcnt = m_fcnt;
    q.push_back(e);
    last_stall = e.stall;
    if (!rs) begin
      slot = '0; zeroed = 1; m_scnt = 0; m_fcnt = 0;
    end else begin
      if (fl) m_fcnt = m_fcnt + 1;
      else if (dep) m_scnt = m_scnt + 1;
      if (fl || dep) begin
        slot = '0; zeroed = 0;
      end else begin
        slot = x; slot.valid = 1; zeroed = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    ins_t cur, add;
    step_init();
    // reset held with random inputs, then release into an R-type
    step(rnd_ins(), 1'b0, 1'b0);
    step(rnd_ins(), 1'b0, 1'b0);
    cur = r_add(5'd5, 5'd1, 5'd2);
    cur.rs1d = 32'h12345678;
    step(cur);
    step(r_add(5'd3, 5'd4, 5'd6));
    // load-use: add held in ID during the stall
    step(ld(5'd5, 5'd1));
    add = r_add(5'd6, 5'd5, 5'd7);
    step(add);
    step(add);
    step(add);
    // false hazards: lui with rs1 field bits, load into x0
    step(ld(5'd5, 5'd1));
    step(lui(5'd9, 5'd5));
    step(ld(5'd0, 5'd1));
    step(r_add(5'd1, 5'd0, 5'd0));
    // flush beats hazard
    step(rnd_ins(), 1'b0, 1'b0);
    step(ld(5'd5, 5'd1));
    step(r_add(5'd6, 5'd5, 5'd7), 1'b1);
    step(r_add(5'd8, 5'd1, 5'd2));
    // store data dependency
    step(rnd_ins(), 1'b0, 1'b0);
    step(ld(5'd5, 5'd1));
    cur = st(5'd2, 5'd5);
    step(cur);
    step(cur);
    step(r_add(5'd4, 5'd1, 5'd2));
    // reset during a stall
    step(ld(5'd5, 5'd1));
    step(r_add(5'd6, 5'd5, 5'd5), 1'b0, 1'b0);
    step(r_add(5'd6, 5'd5, 5'd5));
    // random traffic; ID instruction holds while stalled
    cur = rnd_ins();
    for (int i = 0; i < 3000; i++) begin
      logic fl, rs;
      fl = ($urandom_range(0, 99) < 8);
      rs = ($urandom_range(0, 99) >= 2);
      step(cur, fl, rs);
      if (!(last_stall && rs)) cur = rnd_ins();
    end
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  task automatic step_init();
    reset = 1'b0;
    fl_i = 1'b0;
    br_i = 0; mr_i = 0; m2r_i = 0; mw_i = 0; as_i = 0; rw_i = 0;
    op_i = 0; pc_i = 0; d1_i = 0; d2_i = 0; imm_i = 0;
    a1_i = 0; a2_i = 0; rd_i = 0; f3_i = 0; f7_i = 0;
    @(posedge clk);
    #1;
    slot = '0; zeroed = 1; m_scnt = 0; m_fcnt = 0; last_stall = 0;
  endtask

endmodule

// File: doc/id_ex_stage_register.md
# id_ex_stage_register

ID/EX pipeline stage of the five-stage RISC-V core: sits directly downstream of the decode-stage control unit and register file. Latches the 9-bit control bundle plus operands for the EX stage each cycle. Detects load-use hazards (stalling PC/IF-ID and inserting a bubble) and squashes its contents on a taken-branch flush.

## Interface
- DATA_WIDTH, 32, width of PC, register operands and immediate
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- Branch_i, Mem_Read_i, Mem_to_Reg_i, Mem_Write_i, ALU_Src_i, Reg_Write_i  in  1 each  decode control bits
- ALU_Op_i  in  3  decode ALU op class (000 R, 001 I-logic, 010 U, 011 B, 100 S, 101 load)
- PC_i, RS1_Data_i, RS2_Data_i, Imm_i  in  DATA_WIDTH  decode-stage values
- RS1_Addr_i, RS2_Addr_i, RD_Addr_i  in  5  register indices from the ID instruction
- Funct3_i  in  3; Funct7_b5_i  in  1  ALU function qualifiers
- Flush_i  in  1  taken branch resolved in EX; kill ID/EX contents
- Stall_o  out  1  combinational; holds PC and IF/ID when high
- Branch_o … Reg_Write_o, ALU_Op_o, PC_o, RS1_Data_o, RS2_Data_o, Imm_o, RS1_Addr_o, RS2_Addr_o, RD_Addr_o, Funct3_o, Funct7_b5_o  out  same widths  registered copies
- Valid_o  out  1  high when the EX-stage slot holds a real instruction

## Operation
- Register contents = {control bundle, data, indices, Valid}; updated every cycle (no enable).
- Operand usage (derived from decode bits): use_rs1 = (ALU_Op_i != 3'b010); use_rs2 = ~ALU_Src_i | Mem_Write_i.
- Hazard = Mem_Read_o & Valid_o & (RD_Addr_o != 0) & ((use_rs1 & RD_Addr_o == RS1_Addr_i) | (use_rs2 & RD_Addr_o == RS2_Addr_i)).
- Stall_o = Hazard & ~Flush_i.
- Next-state select, priority order:
  - reset low: all registers zero.
  - Flush_i high: bubble (all control bits, ALU_Op, Valid cleared; data fields don't-care, implementation zeroes them).
  - Hazard high: bubble, same as flush.
  - otherwise: capture all inputs, Valid <= 1.
- Bubble never asserts Reg_Write_o, Mem_Write_o, Mem_Read_o or Branch_o.
- Stall lasts exactly one cycle per load-use pair: bubble clears Valid_o/Mem_Read_o, so Hazard drops the following cycle.

## Timing
- Reset: every output 0 on the first edge with reset low, including Valid_o and Stall_o (Stall_o follows from cleared state).
- Latency: input to output 1 cycle.
- Stall_o purely combinational from current register state and ID inputs; no same-cycle path from Flush_i to registers except via select logic.
- Flush and hazard same cycle: flush wins, Stall_o = 0 (wrong-path ID instruction is killed upstream by same Flush_i).
- Reset asserted mid-stall: next edge clears state; Stall_o drops that cycle.
- RD_Addr_o = x0 load never stalls.

## Configuration
- ID_EX_STALL_CNT_EN defined: adds outputs Stall_Cnt_o[31:0] and Flush_Cnt_o[31:0]; increment by 1 on each edge where Stall_o, respectively Flush_i, is high (flush has priority; never both); wrap from 0xFFFFFFFF to 0; cleared by reset.
- Undefined: counters and ports absent; behaviour otherwise identical.

## Test plan
- Reset: hold reset=0 two cycles with random inputs -> all outputs 0, Stall_o=0; release -> first inputs appear one cycle later with Valid_o=1.
- Pass-through: R-type (ALU_Op=000, Reg_Write=1, RD=5, RS1_Data=0x12345678) -> next cycle outputs match, Stall_o=0.
- Load-use: lw x5 (Mem_Read=1, RD=5) then add x6,x5,x7 in ID -> Stall_o=1 one cycle, next cycle bubble (Valid_o=0, all control 0), then add captured, Stall_o=0.
- False-hazard filter: lw x5 then lui x9 (ALU_Op=010, RS1_Addr=5 field bits) -> Stall_o=0; lw x0 then add using x0 -> Stall_o=0.
- Flush vs hazard: lw x5 in EX, dependent add in ID, Flush_i=1 same cycle -> Stall_o=0, next cycle bubble, Flush_Cnt_o=1, Stall_Cnt_o=0 when ID_EX_STALL_CNT_EN defined.
- Store dependency: lw x5 then sw x5,0(x2) (ALU_Src=1, Mem_Write=1, RS2=5) -> Stall_o=1 one cycle, Stall_Cnt_o increments to 1.
